regfile_param: RTL and testbench
================================

# regfile_param

Parametrised, scoreboarded register file for the CPU datapath. It replaces the fixed 32 x 32 register file and keeps the same place between decode (operand fetch) and writeback. It adds:
- width and depth parameters;
- a hardware clear sequencer that zeroes every entry after reset;
- per-register busy (scoreboard) bits so decode can detect pending writes;
- optional write-to-read bypass.

## Interface
- `DATA_W`, 32, register width in bits.
- `DEPTH`, 32, number of registers; power of two, >= 2.
- `ADDR_W`, `$clog2(DEPTH)`, register index width.
- `ZERO_REG`, 1, when 1, entry 0 reads as 0, and writes and reserves to it are ignored.

Ports:
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — asynchronous, active-high reset.
- `rs1` input `ADDR_W` — read index, port 1.
- `rs2` input `ADDR_W` — read index, port 2.
- `op1` output `DATA_W` — read data, port 1 (combinational).
- `op2` output `DATA_W` — read data, port 2 (combinational).
- `op1_busy` output 1 — `rs1` has an outstanding reservation.
- `op2_busy` output 1 — `rs2` has an outstanding reservation.
- `rd` input `ADDR_W` — write index.
- `wr_en` input 1 — write `wr_data` to `rd` on the next rising edge.
- `wr_data` input `DATA_W` — write data.
- `rsv_en` input 1 — mark `rsv_rd` busy (decode issues a producer).
- `rsv_rd` input `ADDR_W` — index to reserve.
- `ready` output 1 — clear sequence done; register file usable.

## Operation
Two-state FSM, `CLEAR` and `RUN`.
- `rst` asserted forces, asynchronously:
  - state = `CLEAR`, clear index = 0;
  - all busy bits = 0, `ready` = 0.
- In `CLEAR`, on each rising edge the entry at the clear index is written to 0 and the index increments. The edge that writes entry `DEPTH-1` moves the FSM to `RUN`.
- While in `CLEAR`:
  - `wr_en` and `rsv_en` are ignored;
  - `op1`, `op2`, `op1_busy` and `op2_busy` all drive 0.
- `RUN` is held until the next `rst`. Assertion of `rst` mid-sequence restarts the clear from index 0.

Behaviour in `RUN`:
- **Read:** `opN` = entry[`rsN`], or 0 if `ZERO_REG` = 1 and `rsN` = 0. `opN_busy` = busy[`rsN`].
- **Write:** if `wr_en` = 1 and the `ZERO_REG` rule allows it, entry[`rd`] <= `wr_data` and busy[`rd`] <= 0 on the same edge.
- **Reserve:** if `rsv_en` = 1 and the `ZERO_REG` rule allows it, busy[`rsv_rd`] <= 1.
- **Reserve and write to the same index in one cycle:** data is written, and the busy bit ends at 1 (the new producer wins).
- **Reserve to an already-busy index:** the bit stays 1. There is no counting, so one write clears it.
- **Write to an index that is not busy:** legal; the data is written and the busy bit stays 0.
- Any `rs1`/`rs2` combination is legal, including `rs1` = `rs2` = `rd`.

## Timing
- Reads are combinational: zero cycle latency from `rsN` to `opN`.
- A write is visible on reads in the cycle after the edge that commits it. With `REGFILE_BYPASS_EN` it is visible in the same cycle (see Configuration).
- A reserve is visible on `opN_busy` in the cycle after `rsv_en`.
- After `rst` deasserts, `ready` rises after exactly `DEPTH` rising edges. With `DEPTH` = 32, `ready` is high from the 32nd edge onward.
- Reset values: `op1` = `op2` = 0, `op1_busy` = `op2_busy` = 0, `ready` = 0.

## Configuration
The single compile-time option is `REGFILE_BYPASS_EN`.
- **Defined:** in `RUN`, if `wr_en` = 1, `rd` = `rsN`, and the `ZERO_REG` rule allows the write, then:
  - `opN` = `wr_data` in the same cycle;
  - `opN_busy` = 0, unless `rsv_en` = 1 with `rsv_rd` = `rsN` in that cycle.
- **Undefined:** no bypass. Reads return stored contents only, and `opN_busy` reflects the registered busy bit only.

## Structure
- Package `regfile_pkg` holds:
  - the state typedef `rf_state_t` {`RF_CLEAR`, `RF_RUN`};
  - the default constants `RF_DATA_W` = 32 and `RF_DEPTH` = 32.
- Sub-module `regfile_scoreboard` holds the busy-bit vector and its reserve/clear/priority logic, plus the async reset. The top level holds the storage array, the clear FSM, the read muxes and the bypass.

## Test plan
- Pulse `rst`, then release it → `ready` = 0 for 32 edges, 1 afterward. Every `op1` read returns 0.
- Write `0xDEADBEEF` to r5, then read `rs1` = 5 next cycle → `op1` = `0xDEADBEEF`. Write `0x1234` to r0 → `rs2` = 0 reads 0.
- Same-cycle write of `0xA5A5A5A5` to r7 with `rs1` = 7:
  - bypass defined → `op1` = `0xA5A5A5A5` that cycle;
  - bypass undefined → `op1` = old value, new value next cycle.
- Reserve r9 → next cycle `op2_busy` = 1 with `rs2` = 9. Write r9 → busy clears next cycle. Reserve and write r9 in the same cycle → busy stays 1.
- Assert `rst` at clear index 10, release after 2 cycles → `ready` rises after 32 further edges. Writes attempted during `CLEAR` have no effect.
- Parameter sweep `DATA_W` = 64, `DEPTH` = 8, `ZERO_REG` = 0 → `ready` after 8 edges. r0 is writable: `0xFFFF_FFFF_FFFF_FFFF` reads back.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reserve sets, write clears, reserve wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_idx,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              busy1,
  output logic              busy2
);

  logic [DEPTH-1:0] busy;

  // The later assignment takes priority, so a new producer beats the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_en)  busy[wr_idx]  <= 1'b0;
      if (rsv_en) busy[rsv_idx] <= 1'b1;
    end
  end

  assign busy1 = busy[rs1];
  assign busy2 = busy[rs2];

endmodule

// File: rtl/regfile_param.sv
// Scoreboarded register file with post-reset clear sequencer.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              op1_busy,
  output logic              op2_busy,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_rd,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic              ZR   = (ZERO_REG != 0);

  rf_state_t         state, state_nx;
  logic [ADDR_W-1:0] cidx, cidx_nx;
  logic              run;
  logic              wr_ok, rsv_ok;
  logic              sb_busy1, sb_busy2;
  logic [DATA_W-1:0] rd1, rd2;
  logic [DATA_W-1:0] dat1, dat2;
  logic              bsy1, bsy2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_CLEAR;
      cidx  <= '0;
    end else begin
      state <= state_nx;
      cidx  <= cidx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cidx_nx  = cidx;
    ready    = 1'b0;
    unique case (state)
      RF_CLEAR: begin
        cidx_nx = cidx + 1'b1;
        if (cidx == LAST) state_nx = RF_RUN;
      end
      RF_RUN: ready = 1'b1;
      default: ;
    endcase
  end

  assign run    = (state == RF_RUN);
  assign wr_ok  = run && wr_en && !(ZR && rd == '0);
  assign rsv_ok = run && rsv_en && !(ZR && rsv_rd == '0);

  // Storage needs no reset: the clear sequencer zeroes it before use.
  always_ff @(posedge clk) begin
    if (!run)       mem[cidx] <= '0;
    else if (wr_ok) mem[rd]   <= wr_data;
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_idx  (rd),
    .rsv_en  (rsv_ok),
    .rsv_idx (rsv_rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );

  assign rd1 = (ZR && rs1 == '0) ? '0 : mem[rs1];
  assign rd2 = (ZR && rs2 == '0) ? '0 : mem[rs2];

`ifdef REGFILE_BYPASS_EN
  logic byp1, byp2;

  assign byp1 = wr_ok && (rd == rs1);
  assign byp2 = wr_ok && (rd == rs2);
  assign dat1 = byp1 ? wr_data : rd1;
  assign dat2 = byp2 ? wr_data : rd2;
  assign bsy1 = byp1 ? (rsv_ok && rsv_rd == rs1) : sb_busy1;
  assign bsy2 = byp2 ? (rsv_ok && rsv_rd == rs2) : sb_busy2;
`else
  assign dat1 = rd1;
  assign dat2 = rd2;
  assign bsy1 = sb_busy1;
  assign bsy2 = sb_busy2;
`endif

  assign op1      = run ? dat1 : '0;
  assign op2      = run ? dat2 : '0;
  assign op1_busy = run && bsy1;
  assign op2_busy = run && bsy2;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed table, corner sequences, random vs model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, rsv_rd;
  logic [31:0] wr_data, op1, op2;
  logic        wr_en, rsv_en, op1_busy, op2_busy, ready;

  logic        s_rst;
  logic [2:0]  s_rs1, s_rs2, s_rd, s_rsv_rd;
  logic [63:0] s_wr_data, s_op1, s_op2;
  logic        s_wr_en, s_rsv_en, s_op1_busy, s_op2_busy, s_ready;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .op1(op1), .op2(op2),
    .op1_busy(op1_busy), .op2_busy(op2_busy), .rd(rd), .wr_en(wr_en),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_rd(rsv_rd), .ready(ready)
  );

  regfile_param #(.DATA_W(64), .DEPTH(8), .ZERO_REG(0)) dut_s (
    .clk(clk), .rst(s_rst), .rs1(s_rs1), .rs2(s_rs2), .op1(s_op1),
    .op2(s_op2), .op1_busy(s_op1_busy), .op2_busy(s_op2_busy), .rd(s_rd),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .rsv_en(s_rsv_en),
    .rsv_rd(s_rsv_rd), .ready(s_ready)
  );

  int nvec = 0;
  int nerr = 0;

  bit          byp;
  bit          m_run = 0;
  logic [31:0] mm [32];
  bit          bm [32];

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  rr;
    logic [31:0] e1, e2;
    logic        b1, b2;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input int a, b, we, r, input logic [31:0] wd,
                              input int re, rr, input logic [31:0] e1, e2,
                              input int b1, b2);
    vec_t v;
    v.rs1 = 5'(a); v.rs2 = 5'(b); v.we = 1'(we); v.rd = 5'(r);
    v.wd = wd; v.re = 1'(re); v.rr = 5'(rr);
    v.e1 = e1; v.e2 = e2; v.b1 = 1'(b1); v.b2 = 1'(b2);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_op(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (byp && wr_en && rd == rs) return wr_data;
    return mm[rs];
  endfunction

  function automatic logic m_busy(input logic [4:0] rs);
    if (rs == 0) return 1'b0;
    if (byp && wr_en && rd == rs) return rsv_en && rsv_rd == rs;
    return bm[rs];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      mm[i] = 32'h0;
      bm[i] = 1'b0;
    end
  endtask

  task automatic m_update();
    if (wr_en && rd != 0) begin
      mm[rd] = wr_data;
      bm[rd] = 1'b0;
    end
    if (rsv_en && rsv_rd != 0) bm[rsv_rd] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_run) m_update();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rsv_en = 0; rd = 0; rsv_rd = 0; wr_data = 0;
  endtask

  task automatic clear_run(input string tag);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      wr_en = 1; rd = 3; wr_data = 32'hFFFF_FFFF;
      rsv_en = 1; rsv_rd = 4;
      @(negedge clk);
      chk({tag, "_ready_lo"}, 64'(ready), 64'h0);
      chk({tag, "_op1_clr"}, 64'(op1), 64'h0);
      chk({tag, "_b2_clr"}, 64'(op2_busy), 64'h0);
      tick();
    end
    idle();
    m_clear();
    m_run = 1;
    @(negedge clk);
    chk({tag, "_ready_hi"}, 64'(ready), 64'h1);
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    byp = 1;
`else
    byp = 0;
`endif
    tbl[0]  = mk(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(5, 0, 1, 0, 32'h1234, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    tbl[2]  = mk(0, 5, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
    tbl[3]  = mk(9, 5, 0, 0, 0, 1, 9, 0, 32'hDEADBEEF, 0, 0);
    tbl[4]  = mk(5, 9, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1);
    tbl[5]  = mk(5, 5, 1, 9, 32'h99, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[6]  = mk(9, 9, 0, 0, 0, 0, 0, 32'h99, 32'h99, 0, 0);
    tbl[7]  = mk(5, 5, 1, 9, 32'h77, 1, 9, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[8]  = mk(5, 9, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h77, 0, 1);
    tbl[9]  = mk(2, 3, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    tbl[10] = mk(9, 9, 0, 0, 0, 0, 0, 32'h77, 32'h77, 1, 1);
    tbl[11] = mk(5, 5, 1, 9, 32'h55, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[12] = mk(9, 2, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0);
    tbl[13] = mk(5, 5, 1, 6, 32'h66, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tbl[14] = mk(6, 6, 0, 0, 0, 0, 0, 32'h66, 32'h66, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 9, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0);

    rst = 1; s_rst = 1;
    rs1 = 3; rs2 = 4; idle();
    s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_rsv_rd = 0;
    s_wr_en = 0; s_rsv_en = 0; s_wr_data = 0;

    @(negedge clk);
    chk("rst_op1", 64'(op1), 64'h0);
    chk("rst_op2", 64'(op2), 64'h0);
    chk("rst_b1", 64'(op1_busy), 64'h0);
    chk("rst_b2", 64'(op2_busy), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    @(posedge clk); #1;
    rst = 0;
    clear_run("clr");

    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      @(negedge clk);
      chk("post_clr_op1", 64'(op1), 64'h0);
      chk("post_clr_b2", 64'(op2_busy), 64'h0);
      tick();
    end

    for (int i = 0; i < 17; i++) begin
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      wr_en = tbl[i].we; rd = tbl[i].rd; wr_data = tbl[i].wd;
      rsv_en = tbl[i].re; rsv_rd = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_op1", i), 64'(op1), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_op2", i), 64'(op2), 64'(tbl[i].e2));
      chk($sformatf("tbl%0d_b1", i), 64'(op1_busy), 64'(tbl[i].b1));
      chk($sformatf("tbl%0d_b2", i), 64'(op2_busy), 64'(tbl[i].b2));
      tick();
    end
    idle();

    rs1 = 0; rs2 = 0;
    wr_en = 1; rd = 7; wr_data = 32'h1111;
    tick();
    rs1 = 7; wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    chk("byp_same", 64'(op1), byp ? 64'hA5A5A5A5 : 64'h1111);
    tick();
    idle();
    @(negedge clk);
    chk("byp_next", 64'(op1), 64'hA5A5A5A5);
    rsv_en = 1; rsv_rd = 8; rs1 = 8;
    tick();
    idle();
    wr_en = 1; rd = 8; wr_data = 32'h88;
    @(negedge clk);
    chk("byp_b_wr", 64'(op1_busy), byp ? 64'h0 : 64'h1);
    chk("byp_d_wr", 64'(op1), byp ? 64'h88 : 64'h0);
    tick();
    wr_data = 32'h89; rsv_en = 1; rsv_rd = 8;
    @(negedge clk);
    chk("byp_b_rw", 64'(op1_busy), byp ? 64'h1 : 64'h0);
    chk("byp_d_rw", 64'(op1), byp ? 64'h89 : 64'h88);
    tick();
    idle();
    @(negedge clk);
    chk("rw_after_d", 64'(op1), 64'h89);
    chk("rw_after_b", 64'(op1_busy), 64'h1);
    tick();

    for (int n = 0; n < 400; n++) begin
      rs1 = 5'($urandom_range(0, 11));
      rs2 = 5'($urandom_range(0, 11));
      rd = 5'($urandom_range(0, 11));
      rsv_rd = 5'($urandom_range(0, 11));
      wr_en = 1'($urandom_range(0, 1));
      rsv_en = ($urandom_range(0, 3) == 0);
      wr_data = $urandom;
      if (n % 37 == 0) begin
        rs1 = rd; rs2 = rd; rsv_rd = rd;
      end
      @(negedge clk);
      chk("rnd_op1", 64'(op1), 64'(m_op(rs1)));
      chk("rnd_op2", 64'(op2), 64'(m_op(rs2)));
      chk("rnd_b1", 64'(op1_busy), 64'(m_busy(rs1)));
      chk("rnd_b2", 64'(op2_busy), 64'(m_busy(rs2)));
      tick();
    end
    idle();

    rst = 1; m_run = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(ready), 64'h0);
    tick();
    tick();
    rst = 0;
    clear_run("reclr");
    rs1 = 5; rs2 = 9;
    @(negedge clk);
    chk("reclr_r5", 64'(op1), 64'h0);
    chk("reclr_r9", 64'(op2), 64'h0);
    chk("reclr_b9", 64'(op2_busy), 64'h0);
    tick();

    s_rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("s_ready_lo", 64'(s_ready), 64'h0);
      tick();
    end
    @(negedge clk);
    chk("s_ready_hi", 64'(s_ready), 64'h1);
    s_wr_en = 1; s_rd = 0; s_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    s_rsv_en = 1; s_rsv_rd = 0;
    tick();
    s_wr_en = 0; s_rsv_en = 0; s_rs1 = 0; s_rs2 = 7;
    @(negedge clk);
    chk("s_r0_data", s_op1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("s_r0_busy", 64'(s_op1_busy), 64'h1);
    chk("s_r7_zero", s_op2, 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
